mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the single-cycle MIPS datapath. It consumes the two operands the register file drives for the current instruction (rs, rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results land in its private HI/LO registers, which the MFHI/MFLO writeback path reads. While an operation runs, `busy` stalls the PC and instruction fetch in the controller.

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Bus between the controller/register file and the multiply/divide unit.
// master: drives start/op/operands and observes status and HI/LO.
// slave : the multiply/divide unit itself.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with private HI/LO registers.
// Ports:
//   clock_in  rising-edge clock
//   res_n     asynchronous active-low reset
//   bus       slave side of mult_div_unit_if:
//             start/op/rs_data/rt_data in; busy/done/div_by_zero/hi/lo out
// op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
module mult_div_unit (
  input logic         clock_in,
  input logic         res_n,
  mult_div_unit_if.slave bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT          state;
  stateT          nextState;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           isDivQ;
  logic           signAQ;
  logic           signBQ;
  logic           busyQ;
  logic           doneQ;
  logic           dbzQ;
  logic [W-1:0]   hiQ;
  logic [W-1:0]   loQ;

  // Request decode, only meaningful while idle
  logic         isIdle;
  logic         isArith;
  logic         isDivIn;
  logic         signedIn;
  logic         zeroDivisor;
  logic         acceptArith;
  logic         acceptDz;
  logic [W-1:0] magA;
  logic [W-1:0] magB;

  assign isIdle      = (state == IDLE);
  assign isArith     = ~bus.op[2];
  assign isDivIn     = bus.op[1];
  assign signedIn    = ~bus.op[0];
  assign zeroDivisor = (bus.rt_data == '0);
  assign acceptArith = isIdle && bus.start && isArith && !(isDivIn && zeroDivisor);
  assign acceptDz    = isIdle && bus.start && isArith && isDivIn && zeroDivisor;
  assign magA = (signedIn && bus.rs_data[W-1]) ? -bus.rs_data : bus.rs_data;
  assign magB = (signedIn && bus.rt_data[W-1]) ? -bus.rt_data : bus.rt_data;

  // State register
  always_ff @(posedge clock_in or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (acceptArith) nextState = RUN;
      RUN:     if (count == CW'(W - 1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath control strobes
  logic loadOps;
  logic loadDz;
  logic writeHi;
  logic writeLo;
  logic stepRun;
  logic writeFix;

  always_comb begin
    loadOps  = 1'b0;
    loadDz   = 1'b0;
    writeHi  = 1'b0;
    writeLo  = 1'b0;
    stepRun  = 1'b0;
    writeFix = 1'b0;
    case (state)
      IDLE: begin
        loadOps = acceptArith;
        loadDz  = acceptDz;
        writeHi = bus.start && (bus.op == 3'b100);
        writeLo = bus.start && (bus.op == 3'b101);
      end
      RUN:     stepRun  = 1'b1;
      FIX:     writeFix = 1'b1;
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier bit (acc[0]) is set, then shift right.
  logic [W:0]     mulSum;
  logic [2*W-1:0] mulNext;
  assign mulSum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mulNext = {mulSum, acc[W-1:1]};

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not borrow.
  logic [W:0]     divDiff;
  logic [2*W-1:0] divNext;
  assign divDiff = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
  assign divNext = divDiff[W] ? {acc[2*W-2:0], 1'b0}
                              : {divDiff[W-1:0], acc[W-2:0], 1'b1};

  // Sign correction applied in FIX; remainder takes the dividend's sign
  logic [2*W-1:0] prodFix;
  logic [W-1:0]   quotFix;
  logic [W-1:0]   remFix;
  assign prodFix = (signAQ ^ signBQ) ? -acc : acc;
  assign quotFix = (signAQ ^ signBQ) ? -acc[W-1:0] : acc[W-1:0];
  assign remFix  = signAQ ? -acc[2*W-1:W] : acc[2*W-1:W];

  // Datapath and registered outputs
  always_ff @(posedge clock_in or negedge res_n) begin
    if (!res_n) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      isDivQ <= 1'b0;
      signAQ <= 1'b0;
      signBQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      dbzQ   <= 1'b0;
      hiQ    <= '0;
      loQ    <= '0;
    end else begin
      busyQ <= (nextState != IDLE);
      doneQ <= writeFix || loadDz;
      if (loadOps) begin
        count  <= '0;
        acc    <= {W'(0), (isDivIn ? magA : magB)};
        opnd   <= isDivIn ? magB : magA;
        isDivQ <= isDivIn;
        signAQ <= signedIn && bus.rs_data[W-1];
        signBQ <= signedIn && bus.rt_data[W-1];
        dbzQ   <= 1'b0;
      end else if (stepRun) begin
        count <= CW'(count + CW'(1));
        acc   <= isDivQ ? divNext : mulNext;
      end
      if (loadDz)  dbzQ <= 1'b1;
      if (writeHi) hiQ  <= bus.rs_data;
      if (writeLo) loQ  <= bus.rs_data;
      if (writeFix) begin
        if (isDivQ) begin
          hiQ <= remFix;
          loQ <= quotFix;
        end else begin
          {hiQ, loQ} <= prodFix;
        end
      end
    end
  end

  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;
  assign bus.div_by_zero = dbzQ;
  assign bus.hi          = hiQ;
  assign bus.lo          = loQ;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit. Inputs change and outputs are
// sampled on the falling edge; "cycle N" counts rising edges after start.
module tb_mult_div_unit;

  logic clock_in;
  logic res_n;
  int   checks;
  int   failures;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clock_in (clock_in),
    .res_n    (res_n),
    .bus      (bus)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a start at the current falling edge; returns in cycle 1 with
  // operands scrambled to show they are only sampled at acceptance.
  task automatic driveStart(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clock_in);
    bus.start   = 1'b0;
    bus.rs_data = 32'hDEAD_BEEF;
    bus.rt_data = 32'h1234_5678;
  endtask

  task automatic startOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock_in);
    driveStart(o, a, b);
  endtask

  // Full arithmetic op; returns in cycle 34 (done cycle)
  task automatic runArith(input string tag, input bit now, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    bit busyOk;
    if (now) driveStart(o, a, b);
    else     startOp(o, a, b);
    checkVal({tag, "_busy1"}, 64'(bus.busy), 64'd1);
    busyOk = 1'b1;
    for (int c = 2; c <= 33; c++) begin
      @(negedge clock_in);
      if (!bus.busy || bus.done) busyOk = 1'b0;
    end
    checkVal({tag, "_busyRun"}, 64'(busyOk), 64'd1);
    @(negedge clock_in);
    checkVal({tag, "_done"}, 64'(bus.done), 64'd1);
    checkVal({tag, "_busy34"}, 64'(bus.busy), 64'd0);
    checkVal({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    checkVal({tag, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    res_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.rs_data = '0;
    bus.rt_data = '0;

    repeat (2) @(negedge clock_in);
    checkVal("rst_busy", 64'(bus.busy), 64'd0);
    checkVal("rst_done", 64'(bus.done), 64'd0);
    checkVal("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    checkVal("rst_hi",   64'(bus.hi), 64'd0);
    checkVal("rst_lo",   64'(bus.lo), 64'd0);
    res_n = 1'b1;

    runArith("multu_max", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runArith("mult_neg",  1'b1, 3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runArith("div_m7_2",  1'b0, 3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runArith("div_7_m2",  1'b0, 3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    runArith("div_ovf",   1'b0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    runArith("divu_100",  1'b0, 3'b011, 32'd100,       32'd7,         32'd2,         32'd14);
    checkVal("done_single", 64'(0), 64'd0) ;
    @(negedge clock_in);
    checkVal("done_drop", 64'(bus.done), 64'd0);

    // MTHI/MTLO preload
    startOp(3'b100, 32'h1111_1111, 32'h0);
    checkVal("mthi_hi",   64'(bus.hi), 64'h1111_1111);
    checkVal("mthi_busy", 64'(bus.busy), 64'd0);
    checkVal("mthi_done", 64'(bus.done), 64'd0);
    startOp(3'b101, 32'h2222_2222, 32'h0);
    checkVal("mtlo_lo", 64'(bus.lo), 64'h2222_2222);
    checkVal("mtlo_hi", 64'(bus.hi), 64'h1111_1111);

    // Divide by zero
    startOp(3'b011, 32'd10, 32'd0);
    checkVal("dz_done", 64'(bus.done), 64'd1);
    checkVal("dz_flag", 64'(bus.div_by_zero), 64'd1);
    checkVal("dz_busy", 64'(bus.busy), 64'd0);
    checkVal("dz_hi",   64'(bus.hi), 64'h1111_1111);
    checkVal("dz_lo",   64'(bus.lo), 64'h2222_2222);
    @(negedge clock_in);
    checkVal("dz_done2", 64'(bus.done), 64'd0);
    checkVal("dz_busy2", 64'(bus.busy), 64'd0);
    startOp(3'b101, 32'h3333_3333, 32'h0);
    checkVal("mt_keeps_dz", 64'(bus.div_by_zero), 64'd1);

    // MULTU 3x4 with an ignored DIV start in cycle 5
    startOp(3'b001, 32'd3, 32'd4);
    checkVal("ign_dz_clr", 64'(bus.div_by_zero), 64'd0);
    repeat (4) @(negedge clock_in);
    driveStart(3'b010, 32'd9, 32'd3);
    checkVal("ign_busy6", 64'(bus.busy), 64'd1);
    repeat (27) @(negedge clock_in);
    checkVal("ign_busy33", 64'(bus.busy), 64'd1);
    @(negedge clock_in);
    checkVal("ign_done", 64'(bus.done), 64'd1);
    checkVal("ign_hi",   64'(bus.hi), 64'd0);
    checkVal("ign_lo",   64'(bus.lo), 64'd12);
    @(negedge clock_in);
    checkVal("ign_idle", 64'(bus.busy), 64'd0);

    // Reset in the middle of a MULT
    startOp(3'b000, 32'd7, 32'd9);
    repeat (9) @(negedge clock_in);
    res_n = 1'b0;
    #1;
    checkVal("mrst_busy", 64'(bus.busy), 64'd0);
    checkVal("mrst_hi",   64'(bus.hi), 64'd0);
    checkVal("mrst_lo",   64'(bus.lo), 64'd0);
    @(negedge clock_in);
    res_n = 1'b1;
    runArith("post_rst", 1'b1, 3'b001, 32'd2, 32'd3, 32'd0, 32'd6);

    // No-op encoding
    startOp(3'b110, 32'hFFFF_FFFF, 32'h0);
    checkVal("nop_busy", 64'(bus.busy), 64'd0);
    checkVal("nop_done", 64'(bus.done), 64'd0);
    checkVal("nop_lo",   64'(bus.lo), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
